register_file: RTL
==================

// Module: register_file
// PURPOSE
//  Parametrised multi-register storage: DEPTH words of WIDTH bits, one synchronous write port, two read ports.
//  Next generation of the fixed 32-bit D register, adding write enable, sync reset, address decode,
//  read bypass and an optional hard-wired zero register.
//  Sits between the datapath ALU and the control/decoder logic as the architectural register set.
// PARAMETERS
//  WIDTH     32  data width of every register, in bits
//  DEPTH     8   number of registers, 2..256; need not be a power of two
//  ADDR_W    3   address width; must satisfy 2**ADDR_W >= DEPTH
//  ZERO_REG  0   1: register 0 always reads 0 and ignores writes
//  BYPASS    1   1: read of the address being written returns wr_data in the same cycle (write-through)
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  reset     in   1       synchronous, active-high; clears all registers
//  we        in   1       write enable
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   WIDTH   write data
//  rd_addr0  in   ADDR_W  read port 0 address
//  rd_data0  out  WIDTH   read port 0 data (combinational)
//  rd_addr1  in   ADDR_W  read port 1 address
//  rd_data1  out  WIDTH   read port 1 data (combinational)
// BEHAVIOUR
//  - Reset: at a posedge clk with reset=1, all DEPTH registers become 0 and we is ignored.
//    With BYPASS=1 and reset=1, rd_data* do not forward wr_data; they show stored contents.
//    Before the first reset, contents are X.
//  - Write: at a posedge clk with reset=0, we=1 and wr_addr<DEPTH, reg[wr_addr] <= wr_data.
//    Write latency is 1 cycle.
//  - Ignored writes: we=1 with wr_addr>=DEPTH is a no-op, as is any write to address 0 when ZERO_REG=1.
//  - Read: rd_dataN = reg[rd_addrN] combinationally, with zero clock latency.
//    rd_dataN is 0 when rd_addrN>=DEPTH, or when rd_addrN==0 and ZERO_REG=1.
//  - Bypass (BYPASS=1): when we=1, reset=0, rd_addrN==wr_addr and the write is not ignored,
//    rd_dataN = wr_data in that same cycle.
//    With BYPASS=0, the read shows the old value until after the edge.
//  - Both read ports may address the same register, or the write address, simultaneously; each is
//    resolved independently.
//  - Reset in the middle of a write sequence: reset wins at that edge, and the write is discarded.
//  - Storage is one state element per register; there is no other state and no FSM.
//    The write decoder is one-hot and gated by we & ~reset.
// STRUCTURE
//  - Shared defines file holds the default WIDTH/ADDR_W constants and the ZERO value, so the ALU,
//    datapath and this block share data widths.
//  - Sub-module register_en, instantiated DEPTH times via generate:
//      - parametrised WIDTH-bit D register with ports q, clk, reset, en, d;
//      - sync active-high reset to 0; loads d when en=1.
//    It replaces the fixed 32-bit register.
//  - Top level contains:
//      - write address decoder;
//      - two DEPTH:1 read muxes, with range check, zero-reg and bypass logic;
//      - generate loop.
// TESTING (directed; clk period 10 ns, WIDTH=32, DEPTH=8, ZERO_REG=0, BYPASS=1 unless stated)
//  1. Reset: reset=1 for 1 edge, then read all 8 addresses on both ports -> every rd_data = 32'h0000_0000.
//  2. Write/readback: write r3=32'h38af_1297, then r5=32'hcd0b_564e; rd_addr0=3, rd_addr1=5
//     -> rd_data0=32'h38af_1297, rd_data1=32'hcd0b_564e; all other registers still 0.
//  3. Bypass: r2=32'h1111_1111; set we=1, wr_addr=2, wr_data=32'hdead_beef, rd_addr0=2 before the edge
//     -> rd_data0=32'hdead_beef in the same cycle.
//     Rerun with BYPASS=0 -> rd_data0=32'h1111_1111 until the edge, then 32'hdead_beef.
//  4. Zero register (ZERO_REG=1): write addr 0 = 32'hffff_ffff -> rd_data0(addr 0)=0 before and after the edge.
//     Write addr 1 = 32'hffff_ffff -> reads 32'hffff_ffff.
//  5. Out of range (DEPTH=6): write addr 7 = 32'h1234_5678 -> no register changes; read of addr 7 returns 0.
//  6. Reset mid-sequence: r4=32'haaaa_5555; then at one edge drive reset=1 with we=1, wr_addr=4,
//     wr_data=32'h0f0f_0f0f -> after the edge, r4=0; no bypass during that cycle.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register set. The ALU and datapath
// import the same package, so all three blocks use one data width.
package register_file_pkg;

  localparam int WIDTH_DEFAULT  = 32;
  localparam int ADDR_W_DEFAULT = 3;
  localparam int DEPTH_DEFAULT  = 8;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Register file access bus: one write port and two combinational read ports.
// master = the decoder/datapath side, slave = the register file.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr0;
  logic [WIDTH-1:0]  rd_data0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [WIDTH-1:0]  rd_data1;

  modport master (
    output we, wr_addr, wr_data, rd_addr0, rd_addr1,
    input  rd_data0, rd_data1
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr0, rd_addr1,
    output rd_data0, rd_data1
  );

endinterface : register_file_if

// File: rtl/register_file_register_en.sv
// WIDTH-bit D register with load enable and synchronous active-high clear.
// One instance holds one architectural register.
module register_en
  import register_file_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d
);

  // Clear has priority over load, so a write coinciding with reset is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register_en

// File: rtl/register_file.sv
// Architectural register set: DEPTH words of WIDTH bits, one synchronous
// write port, two combinational read ports with optional write-through
// bypass and an optional hard-wired zero register 0.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);

  logic [DEPTH-1:0] wr_en;
  logic             write_ok;
  logic [WIDTH-1:0] regs [DEPTH];

  // A write that lands on no in-range, writable register leaves every
  // enable low, so write_ok doubles as "this write is not ignored".
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
        r = regs[i];
      end
    end
    if (BYPASS != 0 && write_ok && addr == bus.wr_addr) begin
      r = bus.wr_data;
    end
    return r;
  endfunction

  // One-hot write decode; out-of-range addresses, the zero register and
  // reset cycles all produce an all-zero enable vector.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.we && !reset && bus.wr_addr == ADDR_W'(i) &&
          !(ZERO_REG != 0 && i == 0)) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  assign write_ok = |wr_en;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    register_en #(
      .WIDTH (WIDTH)
    ) u_reg (
      .q     (regs[g]),
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[g]),
      .d     (bus.wr_data)
    );
  end

  // Both read ports resolve independently through the same mux/bypass logic.
  always_comb begin
    bus.rd_data0 = read_port(bus.rd_addr0);
    bus.rd_data1 = read_port(bus.rd_addr1);
  end

endmodule : register_file
